// File: rtl/jit_emit_queue_if.sv
// ---------------------------------------------------------------------------
// jit_emit_queue_if
// Bundles the sequencer-facing inputs and the ARM-word output stream of
// jit_emit_queue.
//   master : the queue (samples sequencer inputs, drives waiting/out_valid/
//            out_data, samples out_ready)
//   slave  : the environment (sequencer + downstream consumer)
// Signals:
//   state, q_select, arm_word, param_byte, param_even, push_wide : sequencer
//   waiting    : stall back to the sequencer
//   out_valid, out_data, out_ready : head-of-queue handshake
// Also provides the sequencer encoding macros (SMNL, FETCH_PARAMS, ITERATE,
// Q_FETCH, Q_ITER) unless the surrounding build already defines them.
// ---------------------------------------------------------------------------
`ifndef JIT_EMIT_QUEUE_DEFS
`define JIT_EMIT_QUEUE_DEFS
`define SMNL 4
`define FETCH_PARAMS 4'd3
`define ITERATE 4'd5
`define Q_FETCH 1'b0
`define Q_ITER 1'b1
`endif

interface jit_emit_queue_if;
  logic [`SMNL-1:0] state;
  logic             q_select;
  logic [31:0]      arm_word;
  logic [7:0]       param_byte;
  logic             param_even;
  logic             push_wide;
  logic             waiting;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;

  modport master (
    input  state, q_select, arm_word, param_byte, param_even, push_wide,
    output waiting, out_valid, out_data,
    input  out_ready
  );

  modport slave (
    output state, q_select, arm_word, param_byte, param_even, push_wide,
    input  waiting, out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/jit_emit_queue.sv
// ---------------------------------------------------------------------------
// jit_emit_queue
// FIFO of emitted ARM instruction words for the JIT sequencer. During ITERATE
// each non-zero ROM word is queued; during FETCH_PARAMS operand bytes are
// collected into a 16-bit accumulator and, on push_wide, a MOVW r0,#acc plus
// STR r0,[sp,#-4]! pair is queued in a single cycle.
// Ports:
//   clk    : clock, all state on posedge
//   reset  : asynchronous, active-high
//   bus    : jit_emit_queue_if.master (sequencer inputs, waiting, output
//            stream out_valid/out_data/out_ready)
//   words_pushed, stall_cycles : 16-bit wrapping counters, only present when
//            the macro JIT_EMIT_STATS_EN is defined
// Parameter DEPTH: number of entries, power of two, >= 4.
// ---------------------------------------------------------------------------
`ifndef JIT_EMIT_QUEUE_DEFS
`define JIT_EMIT_QUEUE_DEFS
`define SMNL 4
`define FETCH_PARAMS 4'd3
`define ITERATE 4'd5
`define Q_FETCH 1'b0
`define Q_ITER 1'b1
`endif

module jit_emit_queue #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  jit_emit_queue_if.master bus
`ifdef JIT_EMIT_STATS_EN
  ,
  output logic [15:0]      words_pushed,
  output logic [15:0]      stall_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Fewer than two free entries <=> count >= DEPTH-1.
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);
  localparam logic [31:0]   STR_WORD = 32'hE52D0004;

  typedef enum logic [1:0] {P_IDLE, P_COLLECT, P_DONE} pstate_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  pstate_t       pstate_reg;
  logic [15:0]   acc_reg;
  logic          out_valid_reg;
  logic [31:0]   out_data_reg;

  logic          accept, fetch_st, iter_push, op_push, pop;
  logic [1:0]    n_push;
  logic [31:0]   word0, movw_word, head_next;
  logic [CW-1:0] count_after_pop, count_next;
  logic [AW-1:0] rd_ptr_next;

  assign bus.waiting   = (count_reg >= STALL_AT);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

  assign accept    = !bus.waiting;
  assign fetch_st  = (bus.state == `FETCH_PARAMS);
  assign iter_push = accept && (bus.state == `ITERATE) && (bus.q_select == `Q_ITER)
                     && (bus.arm_word != 32'd0);
  assign op_push   = accept && fetch_st && (pstate_reg == P_COLLECT) && bus.push_wide;
  assign pop       = out_valid_reg && bus.out_ready;

  // MOVW r0,#imm16: imm4 in [19:16], imm12 in [11:0].
  assign movw_word = 32'hE3000000 | {12'h000, acc_reg[15:12], 4'h0, acc_reg[11:0]};
  // The two push sources are mutually exclusive (they need different states).
  assign word0     = op_push ? movw_word : bus.arm_word;
  assign n_push    = op_push ? 2'd2 : (iter_push ? 2'd1 : 2'd0);

  // Next head word: an entry that survives this cycle's pop is already in
  // storage; otherwise the head is the first word being pushed right now,
  // which gives single-cycle push-to-valid latency on an empty queue.
  always_comb begin
    count_after_pop = count_reg - CW'(pop);
    rd_ptr_next     = rd_ptr_reg + AW'(pop);
    count_next      = count_after_pop + CW'(n_push);
    if (count_after_pop != '0) begin
      head_next = mem[rd_ptr_next];
    end else if (n_push != 2'd0) begin
      head_next = word0;
    end else begin
      head_next = out_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (n_push != 2'd0) begin
      mem[wr_ptr_reg] <= word0;
    end
    if (n_push == 2'd2) begin
      mem[wr_ptr_reg + AW'(1)] <= STR_WORD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      pstate_reg    <= P_IDLE;
      acc_reg       <= '0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_reg + AW'(n_push);
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      out_data_reg  <= head_next;
      // Sequencer inputs are ignored entirely while stalled.
      if (accept) begin
        if (!fetch_st) begin
          pstate_reg <= P_IDLE;
        end else begin
          case (pstate_reg)
            P_IDLE: begin
              if (bus.q_select == `Q_FETCH) begin
                pstate_reg <= P_COLLECT;
                acc_reg    <= '0;
              end
            end
            P_COLLECT: begin
              if (bus.push_wide) begin
                pstate_reg <= P_DONE;
              end else if (bus.param_even) begin
                acc_reg <= {acc_reg[7:0], bus.param_byte};
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef JIT_EMIT_STATS_EN
  logic [15:0] words_pushed_reg, stall_cycles_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_pushed_reg <= '0;
      stall_cycles_reg <= '0;
    end else begin
      words_pushed_reg <= words_pushed_reg + 16'(n_push);
      stall_cycles_reg <= stall_cycles_reg + 16'(bus.waiting);
    end
  end

  assign words_pushed = words_pushed_reg;
  assign stall_cycles = stall_cycles_reg;
`endif
endmodule

// File: tb/tb_jit_emit_queue.sv
// ---------------------------------------------------------------------------
// tb_jit_emit_queue
// Self-checking bench: a queue-based reference model advanced on every clock
// edge, a negedge compare process, directed scenarios with literal words,
// then a randomized phase. Define JIT_EMIT_STATS_EN to cover the counters.
// ---------------------------------------------------------------------------
`ifndef JIT_EMIT_QUEUE_DEFS
`define JIT_EMIT_QUEUE_DEFS
`define SMNL 4
`define FETCH_PARAMS 4'd3
`define ITERATE 4'd5
`define Q_FETCH 1'b0
`define Q_ITER 1'b1
`endif

module tb_jit_emit_queue;
  localparam int DEPTH = 8;
  localparam logic [31:0] STR_W = 32'hE52D0004;
  localparam logic [`SMNL-1:0] ST_F    = `FETCH_PARAMS;
  localparam logic [`SMNL-1:0] ST_I    = `ITERATE;
  localparam logic [`SMNL-1:0] ST_NONE = '0;
  localparam logic QF = `Q_FETCH;
  localparam logic QI = `Q_ITER;

  logic clk = 1'b0;
  logic reset = 1'b0;
  jit_emit_queue_if bus();
`ifdef JIT_EMIT_STATS_EN
  logic [15:0] words_pushed, stall_cycles;
`endif

  jit_emit_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef JIT_EMIT_STATS_EN
    ,
    .words_pushed (words_pushed),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit verbose = 1'b1;
  logic [31:0] popped[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  int          mphase;      // 0 idle, 1 collecting bytes, 2 pair emitted
  logic [15:0] macc;
  logic [15:0] m_words, m_stall;
  bit          m_ok;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mphase  = 0;
      macc    = '0;
      m_words = '0;
      m_stall = '0;
    end else begin
      m_ok = (mq.size() <= DEPTH - 2);
      if (!m_ok) m_stall++;
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      if (m_ok) begin
        if (bus.state == ST_I && bus.q_select == QI && bus.arm_word != 0) begin
          mq.push_back(bus.arm_word);
          m_words++;
        end
        if (bus.state != ST_F) mphase = 0;
        else if (mphase == 0) begin
          if (bus.q_select == QF) begin mphase = 1; macc = '0; end
        end else if (mphase == 1) begin
          if (bus.push_wide) begin
            mq.push_back(32'hE3000000 + 32'(macc / 4096) * 32'h10000 + 32'(macc % 4096));
            mq.push_back(STR_W);
            m_words += 16'd2;
            mphase = 2;
          end else if (bus.param_even) begin
            macc = 16'((32'(macc) * 256 + 32'(bus.param_byte)) % 65536);
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_waiting", bus.waiting, 0);
      check("rst_out_data", bus.out_data, 0);
`ifdef JIT_EMIT_STATS_EN
      check("rst_words_pushed", words_pushed, 0);
      check("rst_stall_cycles", stall_cycles, 0);
`endif
    end else begin
      check("waiting", bus.waiting, mq.size() > DEPTH - 2);
      check("out_valid", bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) check("out_data", bus.out_data, mq[0]);
`ifdef JIT_EMIT_STATS_EN
      check("words_pushed", words_pushed, m_words);
      check("stall_cycles", stall_cycles, m_stall);
`endif
      if (bus.out_valid && bus.out_ready) begin
        popped.push_back(bus.out_data);
        if (verbose) $display("pop %08h at %0t", bus.out_data, $time);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic idle_inputs();
    bus.state = ST_NONE; bus.q_select = QF; bus.arm_word = '0;
    bus.param_byte = '0; bus.param_even = 1'b0; bus.push_wide = 1'b0;
  endtask

  task automatic issue(input logic [`SMNL-1:0] st, input logic qs, input logic [31:0] aw,
                       input logic [7:0] pb, input logic pe, input logic pw);
    int guard;
    guard = 0;
    bus.state = st; bus.q_select = qs; bus.arm_word = aw;
    bus.param_byte = pb; bus.param_even = pe; bus.push_wide = pw;
    while (bus.waiting && guard < 100) begin @(posedge clk); #1; guard++; end
    check("issue_accept", bus.waiting, 0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle_inputs();
    bus.out_ready = 1'b1;
    while ((mq.size() != 0 || bus.out_valid) && n < 64) begin @(posedge clk); #1; n++; end
    check("drain_done", bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic operand(input logic [7:0] b0, input logic [7:0] b1);
    issue(ST_F, QF, 0, 8'h00, 0, 0);
    issue(ST_F, QF, 0, b0, 1, 0);
    issue(ST_F, QF, 0, b1, 1, 0);
    issue(ST_F, QF, 0, 8'h00, 0, 1);
  endtask

  initial begin
    idle_inputs();
    bus.out_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("post_reset_valid", bus.out_valid, 0);
    check("post_reset_waiting", bus.waiting, 0);

    // ITERATE words, zero word is dropped
    popped.delete();
    bus.out_ready = 1'b1;
    issue(ST_I, QI, 32'hE1A00000, 0, 0, 0);
    issue(ST_I, QI, 32'hE2800001, 0, 0, 0);
    issue(ST_I, QI, 32'h00000000, 0, 0, 0);
    drain();
    check("iter_count", popped.size(), 2);
    check("iter_w0", popped[0], 32'hE1A00000);
    check("iter_w1", popped[1], 32'hE2800001);

    // operand collection, extra push_wide in P_DONE emits nothing
    popped.delete();
    operand(8'h12, 8'h34);
    issue(ST_F, QF, 0, 8'h00, 0, 1);
    check("op_model_len", mq.size(), 2);
    drain();
    check("op_count", popped.size(), 2);
    check("op_movw", popped[0], 32'hE3010234);
    check("op_str", popped[1], STR_W);

    // full: 7 words stall, 8th held until one pop
    popped.delete();
    for (int i = 1; i <= 7; i++) issue(ST_I, QI, 32'hB0000000 + 32'(i), 0, 0, 0);
    check("full_waiting", bus.waiting, 1);
    bus.arm_word = 32'hB0000008;
    repeat (3) begin @(posedge clk); #1; end
    check("full_hold_len", mq.size(), 7);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("full_after_pop_wait", bus.waiting, 0);
    @(posedge clk); #1;
    check("full_8th_in", bus.waiting, 1);
    drain();
    check("full_count", popped.size(), 8);
    for (int i = 0; i < 8; i++) check("full_order", popped[i], 32'hB0000001 + 32'(i));

    // concurrent push/pop at high occupancy, pointers wrap twice
    popped.delete();
    for (int i = 1; i <= 6; i++) issue(ST_I, QI, 32'hC0000000 + 32'(i), 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int i = 7; i <= 16; i++) issue(ST_I, QI, 32'hC0000000 + 32'(i), 0, 0, 0);
    check("conc_len", mq.size(), 6);
    check("conc_waiting", bus.waiting, 0);
    drain();
    check("conc_count", popped.size(), 16);
    for (int i = 0; i < 16; i++) check("conc_order", popped[i], 32'hC0000001 + 32'(i));

    // reset mid-collection with 3 words queued
    popped.delete();
    for (int i = 1; i <= 3; i++) issue(ST_I, QI, 32'hD0000000 + 32'(i), 0, 0, 0);
    issue(ST_F, QF, 0, 8'h00, 0, 0);
    issue(ST_F, QF, 0, 8'h55, 1, 0);
    #2 reset = 1'b1;
    #1 check("rst_mid_valid", bus.out_valid, 0);
    idle_inputs();
    @(posedge clk); #1 reset = 1'b0;
    operand(8'hAB, 8'hCD);
    drain();
    check("rst_count", popped.size(), 2);
    check("rst_movw", popped[0], 32'hE30A0BCD);
    check("rst_str", popped[1], STR_W);

`ifdef JIT_EMIT_STATS_EN
    #2 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    operand(8'h12, 8'h34);
    issue(ST_I, QI, 32'hE1A00000, 0, 0, 0);
    issue(ST_I, QI, 32'hE2800001, 0, 0, 0);
    check("stats_words4", words_pushed, 4);
    for (int i = 1; i <= 3; i++) issue(ST_I, QI, 32'hF0000000 + 32'(i), 0, 0, 0);
    idle_inputs();
    repeat (5) begin @(posedge clk); #1; end
    check("stats_stall5", stall_cycles, 5);
    drain();
`endif

    // randomized phase
    verbose = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.state = (r < 4) ? ST_F : ((r < 8) ? ST_I : `SMNL'($urandom_range(0, 15)));
      if ($urandom_range(0, 5) != 0) bus.q_select = (bus.state == ST_F) ? QF : QI;
      else bus.q_select = 1'($urandom_range(0, 1));
      bus.arm_word   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      bus.param_byte = 8'($urandom());
      bus.param_even = 1'($urandom_range(0, 1));
      bus.push_wide  = ($urandom_range(0, 7) == 0);
      bus.out_ready  = (i < 800) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
